// File: rtl/hdc_pkg.sv
// Shared HDC encoder constants and the batch scheduler state encoding.
package hdc_pkg;

    localparam int HV_DIM        = 2048;
    localparam int FEATURE_COUNT = 64;
    localparam int DIMS_PER_CC   = 64;
    localparam int SHIFTS        = HV_DIM / DIMS_PER_CC;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAMPLE,
        FETCH,
        ENCODE,
        EMIT,
        DONE
    } sched_state_t;

    // States in which the scheduler waits on a downstream block and can time out.
    function automatic logic is_timed(input sched_state_t s);
        return (s == FETCH) || (s == ENCODE);
    endfunction

endpackage

// File: rtl/hdc_sample_sched_timeout_ctr.sv
// Wait-cycle counter for the scheduler; expired_o flags the cycle that completes TIMEOUT counted cycles.
// Zero latency on expired_o, clear has priority over increment.
module sched_timeout_ctr #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i && !clr_i && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/hdc_sample_sched.sv
// Batch scheduler: accept sample -> level fetch -> encode -> hand HV to consumer, one sample in flight.
// Latency: accept to m_valid is 3 cycles plus level-fetch and encoder wait cycles.
// Backpressure: m_valid held with sample_idx stable until m_ready; no new sample is taken meanwhile.
module hdc_sample_sched
    import hdc_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int TIMEOUT  = 1024,
    parameter int TO_W     = 11
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                run_start,
    input  logic [SAMPLE_W-1:0] cfg_num_samples,
    input  logic                cfg_train,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                lvl_fetch,
    input  logic                lvl_done,
    output logic                start_encoding,
    input  logic                encoding_done,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_train,
    output logic [SAMPLE_W-1:0] sample_idx,
    output logic                busy,
    output logic                run_done,
    output logic                err_timeout
);

    sched_state_t        state_q;
    logic [SAMPLE_W-1:0] num_q;
    logic [SAMPLE_W-1:0] idx_q;
    logic                train_q;
    logic                fetch_q;
    logic                start_q;
    logic                done_q;
    logic                err_q;

    logic take_sample;
    logic lvl_hit;
    logic enc_hit;
    logic to_clr;
    logic to_inc;
    logic to_expired;

    // Done inputs are ignored in the cycle their request pulse is still outstanding.
    assign take_sample = (state_q == WAIT_SAMPLE) && s_valid;
    assign lvl_hit     = (state_q == FETCH) && !fetch_q && lvl_done;
    assign enc_hit     = (state_q == ENCODE) && !start_q && encoding_done;

    assign to_clr = en && (take_sample || lvl_hit);
    assign to_inc = en && is_timed(state_q);

    sched_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk       (clk),
        .nrst      (nrst),
        .clr_i     (to_clr),
        .inc_i     (to_inc),
        .expired_o (to_expired)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            train_q <= 1'b0;
            fetch_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            fetch_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_start) begin
                        num_q   <= cfg_num_samples;
                        train_q <= cfg_train;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= (cfg_num_samples == '0) ? DONE : WAIT_SAMPLE;
                    end
                end
                WAIT_SAMPLE: begin
                    if (take_sample) begin
                        fetch_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (lvl_hit) begin
                        start_q <= 1'b1;
                        state_q <= ENCODE;
                    end else if (to_expired) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                ENCODE: begin
                    if (enc_hit) begin
                        state_q <= EMIT;
                    end else if (to_expired) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (idx_q == num_q - SAMPLE_W'(1)) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + SAMPLE_W'(1);
                            state_q <= WAIT_SAMPLE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pulses held across an en=0 gap are delivered once en returns.
    assign s_ready        = en && take_sample;
    assign lvl_fetch      = en && fetch_q;
    assign start_encoding = en && start_q;
    assign run_done       = en && done_q;

    assign m_valid     = (state_q == EMIT);
    assign m_train     = (state_q == EMIT) && train_q;
    assign sample_idx  = idx_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: doc/hdc_sample_sched.md
Name: hdc_sample_sched

Overview:
Batch-level scheduler for the one-shot HDC encoder. It pulls samples from the feature input buffer and triggers the level-HV fetch for each one. It then pulses start_encoding into the encoding datapath, waits for encoding_done, and hands the result to the downstream consumer (training accumulator or associative-memory search) over a valid/ready handshake. It sits between the system control registers and encoding_top, and is the only block that drives start_encoding.

Parameters:
SAMPLE_W, 16, width of the sample count and sample index.
TIMEOUT, 1024, max cycles spent waiting in FETCH or ENCODE before abort; must fit in TO_W bits.
TO_W, 11, timeout counter width.

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
en  in  1  global enable; low freezes all state, counters and outputs
run_start  in  1  one-cycle pulse; starts a batch
cfg_num_samples  in  SAMPLE_W  samples in batch; latched on accepted run_start
cfg_train  in  1  1=train, 0=infer; latched on accepted run_start
s_valid  in  1  input buffer holds a complete sample
s_ready  out  1  sample accepted this cycle
lvl_fetch  out  1  one-cycle pulse; start level-HV lookup for the accepted sample
lvl_done  in  1  level HVs stable on level_hvs
start_encoding  out  1  one-cycle pulse to encoding_top
encoding_done  in  1  from encoding_top; encoded_hv valid
m_valid  out  1  encoded HV ready for consumer
m_ready  in  1  consumer accepts
m_train  out  1  latched mode, qualifies m_valid
sample_idx  out  SAMPLE_W  index of the sample in flight
busy  out  1  high in any state except IDLE
run_done  out  1  one-cycle pulse at batch end
err_timeout  out  1  sticky; cleared only by reset or accepted run_start

Behaviour:
- Reset (nrst=0 at posedge) forces state IDLE and clears all counters. Every output resets to 0.
- When en=0 the FSM, counters and latched config hold. Pulse outputs (s_ready, lvl_fetch, start_encoding, run_done) are forced to 0. Inputs are ignored that cycle.
- IDLE: run_start=1 latches cfg_num_samples and cfg_train, sets sample_idx=0 and clears err_timeout.
  - If the latched count is 0: go to DONE.
  - Otherwise: go to WAIT_SAMPLE.
- run_start is ignored outside IDLE.
- WAIT_SAMPLE: s_ready=s_valid (combinational). On s_valid, go to FETCH and pulse lvl_fetch on the following cycle (registered).
- FETCH: waits for lvl_done. lvl_done is sampled starting the cycle after the lvl_fetch pulse. On lvl_done, go to ENCODE and pulse start_encoding on the first ENCODE cycle.
- ENCODE: encoding_done is sampled starting the cycle after the start_encoding pulse; done asserted in the pulse cycle itself is ignored. On encoding_done, go to EMIT.
- EMIT: m_valid=1 and m_train=latched mode. On m_valid && m_ready:
  - If sample_idx==count-1: go to DONE.
  - Otherwise: sample_idx++ and go to WAIT_SAMPLE.
- m_valid must remain stable until accepted.
- DONE: run_done=1 for one cycle, then go to IDLE.
- Timeout counter: cleared on entering FETCH or ENCODE and incremented each enabled cycle spent there. Reaching TIMEOUT sets err_timeout, pulses run_done and goes to IDLE. sample_idx holds the failing index.
- Minimum per-sample latency, with immediate lvl_done, encoding_done and m_ready: s_valid acceptance to m_valid is 3 cycles plus the encoder latency.
- Single sample in flight; no overlap between samples.
- Reset mid-operation aborts the batch with no run_done.
- sample_idx wraps never: the count is limited to 2^SAMPLE_W-1.

Decomposition:
- Shared package hdc_pkg carries HV_DIM, FEATURE_COUNT, DIMS_PER_CC, SHIFTS, and a new enum sched_state_t {IDLE, WAIT_SAMPLE, FETCH, ENCODE, EMIT, DONE}.
- One natural sub-module: sched_timeout_ctr (clear / enable / expired) in place of inline counter logic.
- Everything else stays flat in hdc_sample_sched.

Test Plan:
- count=3, train=1, s_valid held, lvl_done 2 cycles after fetch, done 10 cycles after start, m_ready=1 -> three start_encoding pulses; m_valid with m_train=1 and sample_idx 0,1,2; one run_done after the third handshake.
- count=0 -> no s_ready, lvl_fetch or start_encoding; run_done 2 cycles after run_start; busy high for exactly 1 cycle.
- count=2, m_ready low for 5 cycles in EMIT -> m_valid held for 5 cycles, sample_idx stable, no second s_ready until the handshake.
- encoding_done never asserts, TIMEOUT=16 -> err_timeout=1 and run_done pulse after 16 ENCODE cycles, then IDLE. A following run_start clears err_timeout.
- en dropped for 4 cycles mid-ENCODE with encoding_done asserted during that window -> no transition; done re-sampled after en returns; timeout count unchanged across the gap.
- nrst low for 1 cycle mid-FETCH, then run_start with count=1 -> all outputs 0 after reset; a clean one-sample batch completes with sample_idx=0.
